// File: rtl/spi_sched_pkg.sv
// spi_sched_pkg: shared state encoding and width helpers for the SPI transaction scheduler.
package spi_sched_pkg;

    typedef enum logic [2:0] {IDLE, GRANT, LAUNCH, WAIT_BUSY, WAIT_DONE, RESP} state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int width_of(input int v);
        return (clog2(v) < 1) ? 1 : clog2(v);
    endfunction

    function automatic int sel_w(input int num_slaves);
        return width_of(num_slaves);
    endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// spi_rr_arbiter: combinational round-robin pick of the first request at or after ptr.
module spi_rr_arbiter
    import spi_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IW = width_of(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      idx
);

    logic [IW-1:0] k;

    // Scan from the farthest offset down so the nearest valid one wins.
    always_comb begin
        idx = '0;
        k = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k = IW'((int'(ptr) + i) % NUM_REQ);
            if (req[k]) idx = k;
        end
        gnt = (en && |req) ? NUM_REQ'(1) << idx : '0;
    end

endmodule

// File: rtl/spi_txn_scheduler.sv
// spi_txn_scheduler: round-robin sharing of one spi_master between NUM_REQ requesters,
// with launch, completion/timeout handling and per-requester response pulses.
module spi_txn_scheduler
    import spi_sched_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_SLAVES     = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int GAP_CYCLES     = 2,
    localparam int SEL_W = sel_w(NUM_SLAVES)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ*SEL_W-1:0]      req_slave,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_err,
    output logic                          m_start,
    output logic [DATA_WIDTH-1:0]         m_tx_data,
    output logic [NUM_SLAVES-1:0]         m_ss_sel,
    input  logic                          m_busy,
    input  logic                          m_done,
    input  logic [DATA_WIDTH-1:0]         m_rx_data,
    output logic                          m_abort,
    output logic                          sched_busy
);

    localparam int IW = width_of(NUM_REQ);
    localparam int TW = width_of(TIMEOUT_CYCLES + 1);
    localparam int GW = width_of(GAP_CYCLES + 1);

    state_t                  state;
    logic [IW-1:0]           ptr;
    logic [IW-1:0]           owner;
    logic [IW-1:0]           idx;
    logic [NUM_REQ-1:0]      gnt;
    logic [TW-1:0]           tcnt;
    logic [GW-1:0]           gap;
    logic [DATA_WIDTH-1:0]   word;
    logic [DATA_WIDTH-1:0]   pick_data;
    logic [SEL_W-1:0]        pick_sel;
    logic                    arb_en;

    assign arb_en     = (state == IDLE) && (gap == '0);
    assign sched_busy = (state != IDLE);

    spi_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req(req_valid),
        .ptr(ptr),
        .en(arb_en),
        .gnt(gnt),
        .idx(idx)
    );

    always_comb begin
        pick_data = '0;
        pick_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IW'(i) == idx) begin
                pick_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                pick_sel = req_slave[i*SEL_W +: SEL_W];
            end
        end
    end

    // An all-zero m_ss_sel after GRANT marks an out-of-range slave index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr <= '0;
            owner <= '0;
            tcnt <= '0;
            gap <= '0;
            word <= '0;
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_data <= '0;
            rsp_err <= 1'b0;
            m_start <= 1'b0;
            m_tx_data <= '0;
            m_ss_sel <= '0;
            m_abort <= 1'b0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            m_start <= 1'b0;
            m_abort <= 1'b0;
            if (gap != '0) gap <= gap - 1'b1;
            case (state)
                IDLE: begin
                    if (|gnt) begin
                        req_ready <= gnt;
                        owner <= idx;
                        word <= pick_data;
                        m_ss_sel <= (int'(pick_sel) < NUM_SLAVES) ? NUM_SLAVES'(1) << pick_sel : '0;
                        ptr <= (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (m_ss_sel == '0) begin
                        rsp_valid <= NUM_REQ'(1) << owner;
                        rsp_data <= '0;
                        rsp_err <= 1'b1;
                        state <= RESP;
                    end else begin
                        m_start <= 1'b1;
                        m_tx_data <= word;
                        state <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    tcnt <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY, WAIT_DONE: begin
                    tcnt <= tcnt + 1'b1;
                    if (m_done || tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        rsp_valid <= NUM_REQ'(1) << owner;
                        rsp_data <= m_done ? m_rx_data : '0;
                        rsp_err <= !m_done;
                        m_abort <= !m_done;
                        state <= RESP;
                    end else if (state == WAIT_BUSY && m_busy) begin
                        state <= WAIT_DONE;
                    end
                end
                RESP: begin
                    rsp_data <= '0;
                    rsp_err <= 1'b0;
                    m_ss_sel <= '0;
                    m_tx_data <= '0;
                    gap <= GW'(GAP_CYCLES);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
